// File: rtl/vic20_loader.sv
// VIC20 download loader: turns the hps_io ioctl byte stream into core config-port writes,
// patches the BASIC end pointers after a PRG load and tracks filled cartridge blocks.
module vic20_loader #(
  parameter logic [15:0] PRG_LIMIT = 16'hA000,
  parameter logic [15:0] CRT_LIMIT = 16'hC000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        blk_clr,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        dl_wr,
  output logic [4:0]  cart_blk,
  output logic        cart_reset,
  output logic        busy
);

  typedef enum logic [4:0] {
    ST_IDLE = 5'd0,  ST_1  = 5'd1,  ST_2  = 5'd2,  ST_3  = 5'd3,  ST_4  = 5'd4,
    ST_5    = 5'd5,  ST_6  = 5'd6,  ST_7  = 5'd7,  ST_8  = 5'd8,  ST_9  = 5'd9,
    ST_10   = 5'd10, ST_11 = 5'd11, ST_12 = 5'd12, ST_13 = 5'd13, ST_14 = 5'd14,
    ST_15   = 5'd15, ST_16 = 5'd16
  } st_t;

  st_t         st_r, st_nx;
  logic [15:0] ptr_r, ptr_nx;
  logic        old_dl_r;
  logic [15:0] addr_nx;
  logic [7:0]  data_nx;
  logic        wr_nx;
  logic [4:0]  blk_set_s, blk_nx;
  logic        creset_nx, busy_nx;
  logic        rise_s, fall_s, hdr_type_s, raw_type_s;
  logic [15:0] limit_s, base_s;

  // Block $A000-$BFFF is bit 4; $8000-$9FFF (I/O and colour RAM) is never a cartridge block.
  function automatic logic [4:0] blk_bit(input logic [2:0] page);
    case (page)
      3'b000:  blk_bit = 5'b00001;
      3'b001:  blk_bit = 5'b00010;
      3'b010:  blk_bit = 5'b00100;
      3'b011:  blk_bit = 5'b01000;
      3'b101:  blk_bit = 5'b10000;
      default: blk_bit = 5'b00000;
    endcase
  endfunction

  function automatic logic [15:0] patch_addr(input logic [2:0] slot);
    case (slot)
      3'd0:    patch_addr = 16'h002D;
      3'd1:    patch_addr = 16'h002E;
      3'd2:    patch_addr = 16'h002F;
      3'd3:    patch_addr = 16'h0030;
      3'd4:    patch_addr = 16'h0031;
      3'd5:    patch_addr = 16'h0032;
      3'd6:    patch_addr = 16'h00AE;
      default: patch_addr = 16'h00AF;
    endcase
  endfunction

  function automatic logic [15:0] bank_base(input logic [1:0] bank);
    case (bank)
      2'd0:    bank_base = 16'h4000;
      2'd1:    bank_base = 16'h6000;
      2'd2:    bank_base = 16'hA000;
      default: bank_base = 16'hB000;
    endcase
  endfunction

  // Next-state, patch sequencing and data-path decode.
  always_comb begin
    rise_s     = ioctl_download & ~old_dl_r;
    fall_s     = ~ioctl_download & old_dl_r;
    hdr_type_s = (ioctl_index == 8'd1) || (ioctl_index == 8'd2);
    raw_type_s = (ioctl_index[4:0] == 5'd3);
    limit_s    = (ioctl_index == 8'd1) ? PRG_LIMIT : CRT_LIMIT;
    base_s     = bank_base(ioctl_index[7:6]);
    ptr_nx     = ptr_r;
    st_nx      = st_r;
    addr_nx    = dl_addr;
    data_nx    = dl_data;
    wr_nx      = 1'b0;
    blk_set_s  = 5'b00000;

    // A new download always wins over an in-flight pointer patch.
    if (rise_s) begin
      st_nx = ST_IDLE;
    end else if (fall_s && ioctl_index == 8'd1) begin
      st_nx = ST_1;
    end else if (st_r == ST_16) begin
      st_nx = ST_IDLE;
    end else if (st_r != ST_IDLE) begin
      st_nx = st_t'(st_r + 5'd1);
    end else begin
      st_nx = st_r;
    end

    if (!rise_s && st_r[0]) begin
      wr_nx   = 1'b1;
      addr_nx = patch_addr(st_r[3:1]);
      data_nx = st_r[1] ? ptr_r[15:8] : ptr_r[7:0];
    end else begin
      wr_nx = 1'b0;
    end

    if (ioctl_download && ioctl_wr) begin
      if (ioctl_index == 8'd0) begin
        if (ioctl_addr >= 25'h0004000 && ioctl_addr <= 25'h0007FFF) begin
          wr_nx   = 1'b1;
          addr_nx = ioctl_addr[15:0] + 16'h8000;
          data_nx = ioctl_dout;
        end else begin
          ptr_nx = ptr_r;
        end
      end else if (hdr_type_s && ioctl_addr == 25'd0) begin
        ptr_nx[7:0] = ioctl_dout;
      end else if (hdr_type_s && ioctl_addr == 25'd1) begin
        ptr_nx[15:8] = ioctl_dout;
      end else if (raw_type_s && ioctl_addr == 25'd0) begin
        wr_nx     = 1'b1;
        addr_nx   = base_s;
        data_nx   = ioctl_dout;
        ptr_nx    = base_s + 16'd1;
        blk_set_s = blk_bit(base_s[15:13]);
      end else if (hdr_type_s || raw_type_s) begin
        // The limit check also keeps ptr from ever wrapping past $FFFF.
        if (ptr_r < limit_s) begin
          wr_nx   = 1'b1;
          addr_nx = ptr_r;
          data_nx = ioctl_dout;
          ptr_nx  = ptr_r + 16'd1;
          if (ioctl_index != 8'd1) begin
            blk_set_s = blk_bit(ptr_r[15:13]);
          end else begin
            blk_set_s = 5'b00000;
          end
        end else begin
          ptr_nx = ptr_r;
        end
      end else begin
        ptr_nx = ptr_r;
      end
    end else begin
      ptr_nx = ptr_r;
    end

    if (blk_clr) begin
      blk_nx = 5'b00000;
    end else begin
      blk_nx = cart_blk | blk_set_s;
    end

    if (blk_clr) begin
      creset_nx = 1'b0;
    end else if (rise_s && (ioctl_index[4:0] == 5'd2 || ioctl_index[4:0] == 5'd3)) begin
      creset_nx = 1'b1;
    end else if (fall_s) begin
      creset_nx = 1'b0;
    end else begin
      creset_nx = cart_reset;
    end

    busy_nx = ioctl_download | (st_nx != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      st_r       <= ST_IDLE;
      ptr_r      <= 16'h0000;
      old_dl_r   <= 1'b0;
      dl_addr    <= 16'h0000;
      dl_data    <= 8'h00;
      dl_wr      <= 1'b0;
      cart_blk   <= 5'b00000;
      cart_reset <= 1'b0;
      busy       <= 1'b0;
    end else begin
      st_r       <= st_nx;
      ptr_r      <= ptr_nx;
      old_dl_r   <= ioctl_download;
      dl_addr    <= addr_nx;
      dl_data    <= data_nx;
      dl_wr      <= wr_nx;
      cart_blk   <= blk_nx;
      cart_reset <= creset_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_vic20_loader.sv
// Directed self-checking bench for vic20_loader: PRG, ROM and cartridge loads,
// pointer patch timing, limit drops, reset and blk_clr corner cases.
module tb_vic20_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n, blk_clr, ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wr, cart_reset, busy;
  logic [4:0]  cart_blk;

  vic20_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .blk_clr(blk_clr),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_wr(dl_wr),
    .cart_blk(cart_blk), .cart_reset(cart_reset), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Write log captured on the falling edge.
  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];
  always @(negedge clk_sys) begin
    if (dl_wr) begin
      wa.push_back(dl_addr);
      wd.push_back(dl_data);
      wc.push_back(cyc);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    tick(1);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    tick(1);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr   = 1'b0;
  endtask

  task automatic end_dl(output int c0);
    tick(1);
    ioctl_download = 1'b0;
    c0 = cyc;
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [15:0] a, input logic [7:0] d);
    if (i < wa.size()) begin
      check({tag, "_addr"}, wa[i], a);
      check({tag, "_data"}, wd[i], d);
    end else begin
      check({tag, "_missing"}, wa.size(), i + 1);
    end
  endtask

  function automatic logic [15:0] patch_exp(input int i);
    case (i)
      0: patch_exp = 16'h002D;
      1: patch_exp = 16'h002E;
      2: patch_exp = 16'h002F;
      3: patch_exp = 16'h0030;
      4: patch_exp = 16'h0031;
      5: patch_exp = 16'h0032;
      6: patch_exp = 16'h00AE;
      default: patch_exp = 16'h00AF;
    endcase
  endfunction

  // Eight patch writes, alternating low/high end byte, first two cycles after the drop, then every 2.
  task automatic chk_patch(input string tag, input logic [15:0] e, input int c0);
    check({tag, "_cnt"}, wa.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk_wr(tag, i, patch_exp(i), (i % 2 == 1) ? e[15:8] : e[7:0]);
      if (i < wc.size()) check({tag, "_cyc"}, wc[i], c0 + 2 + 2 * i);
    end
  endtask

  int c0;
  int busy_low;
  int n_late;

  initial begin
    reset_n = 1'b0; blk_clr = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = 25'd0; ioctl_dout = 8'd0;
    tick(2);
    check("rst_addr", dl_addr, 16'h0000);
    check("rst_data", dl_data, 8'h00);
    check("rst_wr", dl_wr, 1'b0);
    check("rst_blk", cart_blk, 5'b00000);
    check("rst_creset", cart_reset, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    tick(2);

    // PRG at $1001
    clear_log();
    start_dl(8'd1);
    send(25'd0, 8'h01); send(25'd1, 8'h10);
    send(25'd2, 8'hAA); send(25'd3, 8'hBB); send(25'd4, 8'hCC);
    tick(2);
    check("prg_cnt", wa.size(), 3);
    chk_wr("prg0", 0, 16'h1001, 8'hAA);
    chk_wr("prg1", 1, 16'h1002, 8'hBB);
    chk_wr("prg2", 2, 16'h1003, 8'hCC);
    check("prg_busy", busy, 1'b1);
    clear_log();
    end_dl(c0);
    busy_low = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk_sys);
      if (!busy && busy_low == 0) busy_low = cyc;
    end
    chk_patch("prg_patch", 16'h1004, c0);
    check("busy_drop", busy_low, c0 + 17);

    // PRG crossing the limit
    clear_log();
    start_dl(8'd1);
    send(25'd0, 8'hFE); send(25'd1, 8'h9F);
    send(25'd2, 8'h11); send(25'd3, 8'h22); send(25'd4, 8'h33); send(25'd5, 8'h44);
    tick(2);
    check("lim_cnt", wa.size(), 2);
    chk_wr("lim0", 0, 16'h9FFE, 8'h11);
    chk_wr("lim1", 1, 16'h9FFF, 8'h22);
    clear_log();
    end_dl(c0);
    tick(24);
    chk_patch("lim_patch", 16'hA000, c0);

    // Raw cartridge, bank 2
    clear_log();
    start_dl(8'h83);
    tick(1);
    check("crt_creset_on", cart_reset, 1'b1);
    send(25'd0, 8'h11); send(25'd1, 8'h22); send(25'd2, 8'h33);
    tick(1);
    check("crt_creset_hold", cart_reset, 1'b1);
    end_dl(c0);
    @(negedge clk_sys);
    check("crt_creset_last", cart_reset, 1'b1);
    @(negedge clk_sys);
    check("crt_creset_off", cart_reset, 1'b0);
    tick(20);
    check("crt_cnt", wa.size(), 3);
    chk_wr("crt0", 0, 16'hA000, 8'h11);
    chk_wr("crt1", 1, 16'hA001, 8'h22);
    chk_wr("crt2", 2, 16'hA002, 8'h33);
    check("crt_blk", cart_blk, 5'b10000);

    // ROM window
    clear_log();
    start_dl(8'd0);
    send(25'h3FFF, 8'h01); send(25'h4000, 8'h02); send(25'h7FFF, 8'h03);
    tick(2);
    end_dl(c0);
    tick(20);
    check("rom_cnt", wa.size(), 2);
    chk_wr("rom0", 0, 16'hC000, 8'h02);
    chk_wr("rom1", 1, 16'hFFFF, 8'h03);

    // Asynchronous reset in the middle of the patch
    start_dl(8'd1);
    send(25'd0, 8'h00); send(25'd1, 8'h20); send(25'd2, 8'h77);
    tick(1);
    clear_log();
    end_dl(c0);
    tick(7);
    reset_n = 1'b0;
    #1;
    check("arst_addr", dl_addr, 16'h0000);
    check("arst_data", dl_data, 8'h00);
    check("arst_wr", dl_wr, 1'b0);
    check("arst_blk", cart_blk, 5'b00000);
    check("arst_busy", busy, 1'b0);
    check("arst_pre_cnt", wa.size(), 3);
    tick(2);
    reset_n = 1'b1;
    tick(20);
    check("arst_post_cnt", wa.size(), 3);

    // blk_clr colliding with a block-set
    clear_log();
    start_dl(8'd2);
    send(25'd0, 8'h00); send(25'd1, 8'h20);
    tick(1);
    ioctl_addr = 25'd2; ioctl_dout = 8'h5A; ioctl_wr = 1'b1; blk_clr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0; blk_clr = 1'b0;
    tick(1);
    check("clr_blk", cart_blk, 5'b00000);
    check("clr_creset", cart_reset, 1'b0);
    send(25'd3, 8'h5B);
    tick(1);
    check("clr_blk_set", cart_blk, 5'b00010);
    end_dl(c0);
    tick(4);
    check("clr_cnt", wa.size(), 2);
    chk_wr("clr0", 0, 16'h2000, 8'h5A);
    chk_wr("clr1", 1, 16'h2001, 8'h5B);

    // New download aborts the patch at ST5
    start_dl(8'd1);
    send(25'd0, 8'h00); send(25'd1, 8'h12); send(25'd2, 8'h55);
    tick(1);
    clear_log();
    end_dl(c0);
    tick(5);
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    send(25'd0, 8'h00); send(25'd1, 8'h13); send(25'd2, 8'h66);
    tick(1);
    n_late = 0;
    foreach (wa[i]) if (wa[i] >= 16'h0030 && wa[i] <= 16'h00AF) n_late++;
    check("abort_late", n_late, 0);
    if (wa.size() > 0) begin
      check("abort_reload_addr", wa[wa.size() - 1], 16'h1300);
      check("abort_reload_data", wd[wa.size() - 1], 8'h66);
    end else begin
      check("abort_reload_cnt", wa.size(), 1);
    end
    check("abort_busy", busy, 1'b1);
    clear_log();
    end_dl(c0);
    tick(24);
    chk_patch("re_patch", 16'h1301, c0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
